// File: rtl/multiplicador_booth_n.sv
// Sequential radix-2 Booth multiplier with N-bit signed/unsigned operands and a 2N-bit product.
// Runs one add-and-shift per clock over W = N+1 bits, then pulses Fin with the new product.
module multiplicador_booth_n #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signo,
    input  logic [N-1:0]   multiplicando,
    input  logic [N-1:0]   multiplicador,
    output logic [2*N-1:0] resultado,
    output logic           Fin,
    output logic           ocupado
);

    // state  | meaning
    // REPOSO | idle, waiting for start; operands sampled here only
    // OPERA  | one Booth add/shift per clock, r_cnt counts iterations left
    // FIN    | Fin pulse for one cycle, product already in resultado
    localparam int W  = N + 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        REPOSO,
        OPERA,
        FIN
    } estado_t;

    estado_t         r_estado;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_m;
    logic [W-1:0]    r_q;
    logic            r_q1;
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    w_m_ext;
    logic [W-1:0]    w_q_ext;
    logic [W-1:0]    w_suma;
    logic [W-1:0]    w_a_sig;
    logic [W-1:0]    w_q_sig;
    logic [2*N-1:0]  w_producto;

    // One extra bit lets unsigned operands run through the same signed Booth recurrence.
    always_comb begin
        w_m_ext = {signo & multiplicando[N-1], multiplicando};
        w_q_ext = {signo & multiplicador[N-1], multiplicador};
    end

    always_comb begin
        w_suma = r_a;
        case ({r_q[0], r_q1})
            2'b10:   w_suma = r_a - r_m;
            2'b01:   w_suma = r_a + r_m;
            default: w_suma = r_a;
        endcase
    end

    always_comb begin
        w_a_sig    = {w_suma[W-1], w_suma[W-1:1]};
        w_q_sig    = {w_suma[0], r_q[W-1:1]};
        w_producto = {w_a_sig[N-2:0], w_q_sig};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= REPOSO;
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            resultado <= '0;
            Fin       <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            case (r_estado)
                REPOSO: begin
                    Fin     <= 1'b0;
                    ocupado <= 1'b0;
                    if (start) begin
                        r_m      <= w_m_ext;
                        r_q      <= w_q_ext;
                        r_a      <= '0;
                        r_q1     <= 1'b0;
                        r_cnt    <= CW'(W);
                        ocupado  <= 1'b1;
                        r_estado <= OPERA;
                    end
                end
                OPERA: begin
                    r_a   <= w_a_sig;
                    r_q   <= w_q_sig;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - CW'(1);
                    // Last iteration: publish the shifted product in the same edge.
                    if (r_cnt == CW'(1)) begin
                        resultado <= w_producto;
                        Fin       <= 1'b1;
                        r_estado  <= FIN;
                    end
                end
                FIN: begin
                    Fin      <= 1'b0;
                    ocupado  <= 1'b0;
                    r_estado <= REPOSO;
                end
                default: begin
                    Fin      <= 1'b0;
                    ocupado  <= 1'b0;
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

endmodule
